ddr_rd_check: RTL

Read-data checker that sits directly downstream of the DDR controller's read channel, consuming R-channel beats for reads issued by the DDR write/read test master. It snoops the AR handshake to learn each burst's start address and length, queues up to DEPTH outstanding bursts, and compares every returned beat against an expected pattern. It reports sticky error status, saturating pass/error counters, and the first failing address and data for on-board debug.

---
 rtl/ddr_rd_check_if.sv | 26 ++
 rtl/ddr_rd_check.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_check_if.sv
// ddr_rd_check_if: read-channel bundle between the DDR test master and the read checker.
//   AR snoop : araddr, arlen, arvalid, arready   (master -> checker)
//   R beats  : rdata, rresp, rlast, rvalid       (master -> checker)
//   back     : rready, cmd_full                  (checker -> master)
interface ddr_rd_check_if;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic        cmd_full;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output araddr, arlen, arvalid, arready, rdata, rresp, rlast, rvalid,
      input  rready, cmd_full
   );

   modport slave (
      input  araddr, arlen, arvalid, arready, rdata, rresp, rlast, rvalid,
      output rready, cmd_full
   );
endinterface

// File: rtl/ddr_rd_check.sv
// ddr_rd_check: snoops AR handshakes into a DEPTH-entry burst queue and checks every
// returned R beat against an expected pattern (exp_base, or exp_base ^ beat address).
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   bus (slave)      AR snoop, R beats, rready / cmd_full back to the issuer
//   exp_base         pattern seed (quasi-static)
//   pat_mode         0: expected = exp_base, 1: expected = exp_base ^ beat_addr
//   clr              synchronous clear of counters and status (queue untouched)
//   busy             queue non-empty
//   burst_ok_cnt     error-free bursts, saturating
//   err_cnt          erroneous beats, saturating
//   err_flag         sticky any-error
//   ovf_flag         sticky AR accepted while queue full
//   first_err_addr   beat address of the first error
//   first_err_data   rdata of the first error
module ddr_rd_check #(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rstn,
   ddr_rd_check_if.slave       bus,
   input  logic [31:0]         exp_base,
   input  logic                pat_mode,
   input  logic                clr,
   output logic                busy,
   output logic [15:0]         burst_ok_cnt,
   output logic [15:0]         err_cnt,
   output logic                err_flag,
   output logic                ovf_flag,
   output logic [31:0]         first_err_addr,
   output logic [31:0]         first_err_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0] addr_mem_q [DEPTH];
   logic [7:0]  len_mem_q  [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    beat_q, beat_d;
   logic          burst_err_q, burst_err_d;
   logic [15:0]   burst_ok_q, burst_ok_d;
   logic [15:0]   err_cnt_q, err_cnt_d;
   logic          err_flag_q, err_flag_d;
   logic          ovf_flag_q, ovf_flag_d;
   logic [31:0]   ferr_addr_q, ferr_addr_d;
   logic [31:0]   ferr_data_q, ferr_data_d;

   logic        empty, full;
   logic [31:0] head_addr, beat_addr, exp_data;
   logic [7:0]  head_len;
   logic        last_beat, beat_acc, beat_err, pop, push_req, push, ovf;

   // Handshake outputs come only from registered occupancy, so rready has no
   // combinational path from rvalid or from a same-cycle AR push.
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == FULL_CNT);
      head_addr = addr_mem_q[rd_ptr_q];
      head_len  = len_mem_q[rd_ptr_q];
      beat_addr = head_addr + {22'd0, beat_q, 2'b00};
      exp_data  = pat_mode ? (exp_base ^ beat_addr) : exp_base;
      last_beat = (beat_q == head_len);
      beat_acc  = bus.rvalid & ~empty;
      beat_err  = beat_acc & ((bus.rdata != exp_data) | (bus.rresp != 2'b00) |
                              (bus.rlast != last_beat));
      // Burst length comes from the queue, not rlast: a missing/early rlast is an
      // error but never desynchronises the queue.
      pop       = beat_acc & last_beat;
      push_req  = bus.arvalid & bus.arready;
      push      = push_req & (~full | pop);
      ovf       = push_req & full & ~pop;
   end

   assign bus.rready   = ~empty;
   assign bus.cmd_full = full;
   assign busy         = ~empty;

   always_comb begin
      count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
      beat_d      = beat_q;
      burst_err_d = burst_err_q;
      burst_ok_d  = burst_ok_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      ovf_flag_d  = ovf_flag_q;
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;

      if (beat_acc) begin
         beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
      end

      if (beat_err) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         err_flag_d = 1'b1;
         if (!err_flag_q) begin
            ferr_addr_d = beat_addr;
            ferr_data_d = bus.rdata;
         end
      end

      if (ovf) begin
         ovf_flag_d = 1'b1;
         err_flag_d = 1'b1;
      end

      if (pop) begin
         burst_err_d = 1'b0;
         if (!(burst_err_q | beat_err) && (burst_ok_q != 16'hFFFF))
            burst_ok_d = burst_ok_q + 16'd1;
      end else if (beat_err) begin
         burst_err_d = 1'b1;
      end

      if (clr) begin
         burst_err_d = 1'b0;
         burst_ok_d  = '0;
         err_cnt_d   = '0;
         err_flag_d  = 1'b0;
         ovf_flag_d  = 1'b0;
         ferr_addr_d = '0;
         ferr_data_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            len_mem_q[i]  <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         beat_q      <= '0;
         burst_err_q <= 1'b0;
         burst_ok_q  <= '0;
         err_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
         ovf_flag_q  <= 1'b0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
      end else begin
         if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.araddr;
            len_mem_q[wr_ptr_q]  <= bus.arlen;
            wr_ptr_q             <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q     <= count_d;
         beat_q      <= beat_d;
         burst_err_q <= burst_err_d;
         burst_ok_q  <= burst_ok_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
         ovf_flag_q  <= ovf_flag_d;
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
      end
   end

   assign burst_ok_cnt   = burst_ok_q;
   assign err_cnt        = err_cnt_q;
   assign err_flag       = err_flag_q;
   assign ovf_flag       = ovf_flag_q;
   assign first_err_addr = ferr_addr_q;
   assign first_err_data = ferr_data_q;

endmodule
